// File: rtl/symbol_word_packer_if.sv
// Symbol-in / word-out handshake bundle for the symbol word packer.
// Symbol side and word side share one interface; clock and reset stay outside.
interface symbol_word_packer_if;
  logic [3:0]  inData;
  logic        inValid;
  logic        inLast;
  logic        outReadyIn;
  logic [31:0] outWord;
  logic [3:0]  outCount;
  logic        outValid;
  logic        inReady;
  logic [2:0]  outSlot;

  modport master (
    output inData,
    output inValid,
    output inLast,
    output inReady,
    input  outReadyIn,
    input  outWord,
    input  outCount,
    input  outValid,
    input  outSlot
  );

  modport slave (
    input  inData,
    input  inValid,
    input  inLast,
    input  inReady,
    output outReadyIn,
    output outWord,
    output outCount,
    output outValid,
    output outSlot
  );
endinterface

// File: rtl/symbol_word_packer.sv
// Packs 4-bit symbols into 32-bit words, slot 0 in the MSB nibble.
// Words close after slot 7 or on an inLast beat; both sides use valid/ready.
module symbol_word_packer #(
  parameter int SYM_W = 4,
  parameter int NSYM  = 8
) (
  input logic                 inClk,
  input logic                 inResetN,
  symbol_word_packer_if.slave bus
);
  localparam int WW = SYM_W * NSYM;
  localparam logic [2:0] LAST_SLOT = 3'(NSYM - 1);

  logic [WW-1:0] acc_q, acc_d;
  logic [WW-1:0] word_q, word_d;
  logic [WW-1:0] merged;
  logic [3:0]    count_q, count_d;
  logic [2:0]    slot_q, slot_d;
  logic          valid_q, valid_d;
  logic          out_free;
  logic          ready_in;
  logic          accept;
  logic          closing;
  logic [4:0]    shamt;

  // Handshake: only a closing beat needs a free output register.
  always_comb begin
    out_free = !valid_q || bus.inReady;
    ready_in = out_free ||
               (slot_q != LAST_SLOT && !bus.inLast);
    accept   = bus.inValid && ready_in;
    closing  = accept &&
               (slot_q == LAST_SLOT || bus.inLast);
    shamt    = {~slot_q, 2'b00};
    merged   = (WW'(bus.inData) << shamt) |
               ((slot_q == 3'd0) ? '0 : acc_q);
  end

  // Next state: accumulate, close a word, or drain the output.
  always_comb begin
    acc_d   = acc_q;
    word_d  = word_q;
    count_d = count_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    if (valid_q && bus.inReady) begin
      valid_d = 1'b0;
    end
    if (closing) begin
      word_d  = merged;
      count_d = {1'b0, slot_q} + 4'd1;
      valid_d = 1'b1;
      slot_d  = 3'd0;
      acc_d   = '0;
    end else if (accept) begin
      acc_d  = merged;
      slot_d = slot_q + 3'd1;
    end
  end

  // State register; reset discards any partial word.
  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      acc_q   <= '0;
      word_q  <= '0;
      count_q <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      word_q  <= word_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign bus.outReadyIn = ready_in;
  assign bus.outWord    = word_q;
  assign bus.outCount   = count_q;
  assign bus.outValid   = valid_q;
  assign bus.outSlot    = slot_q;
endmodule

// File: tb/tb_symbol_word_packer.sv
// Scoreboard bench for symbol_word_packer.
// Driver pushes expected words; a negedge monitor pops on each transfer.
module tb_symbol_word_packer;
  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  symbol_word_packer_if bus ();

  symbol_word_packer dut (
    .inClk    (clk),
    .inResetN (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] w,
                      input logic [3:0] c);
    exp_t x;
    x.w = w;
    x.c = c;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [3:0] d,
                      input logic l,
                      output int waits);
    bus.inData  = d;
    bus.inValid = 1'b1;
    bus.inLast  = l;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.outReadyIn) break;
      waits++;
      if (waits > 50) begin
        nvec++;
        nerr++;
        $display("FAIL send_timeout: got stall, want accept");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every word transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.outValid && bus.inReady) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_word: got %h/%0d, want none",
                 bus.outWord, bus.outCount);
      end else begin
        e = exp_q.pop_front();
        chk("mon_word", bus.outWord, e.w);
        chk("mon_count", 32'(bus.outCount), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, want finish");
    $fatal(1);
  end

  initial begin
    int w;
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.inData  = '0;
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
    bus.inReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.outValid), 32'd0);
    chk("rst_word", bus.outWord, 32'h0);
    chk("rst_count", 32'(bus.outCount), 32'd0);
    chk("rst_slot", 32'(bus.outSlot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word 1..8, one-cycle latency, one-cycle valid.
    push(32'h12345678, 4'd8);
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), 1'b0, w);
    end
    chk("t1_valid", 32'(bus.outValid), 32'd1);
    chk("t1_word", bus.outWord, 32'h12345678);
    chk("t1_count", 32'(bus.outCount), 32'd8);
    idle(1);
    chk("t1_drop", 32'(bus.outValid), 32'd0);

    // Early close, then a clean full word.
    push(32'hABC00000, 4'd3);
    push(32'h01234567, 4'd8);
    send(4'hA, 1'b0, w);
    send(4'hB, 1'b0, w);
    send(4'hC, 1'b1, w);
    chk("t2_slot0", 32'(bus.outSlot), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(4'(i), 1'b0, w);
    end
    idle(2);

    // Back-pressure: stall only on the slot-7 beat.
    bus.inReady = 1'b0;
    push(32'h89ABCDEF, 4'd8);
    push(32'h01234567, 4'd8);
    for (int i = 8; i < 16; i++) begin
      send(4'(i), 1'b0, w);
    end
    for (int i = 0; i < 7; i++) begin
      send(4'(i), 1'b0, w);
      chk("t3_nostall", 32'(w), 32'd0);
    end
    bus.inData  = 4'd7;
    bus.inValid = 1'b1;
    bus.inLast  = 1'b0;
    #1;
    chk("t3_stall", 32'(bus.outReadyIn), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_stall2", 32'(bus.outReadyIn), 32'd0);
    chk("t3_slot7", 32'(bus.outSlot), 32'd7);
    chk("t3_hold", bus.outWord, 32'h89ABCDEF);
    bus.inReady = 1'b1;
    #1;
    chk("t3_release", 32'(bus.outReadyIn), 32'd1);
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
    chk("t3_valid", 32'(bus.outValid), 32'd1);
    chk("t3_word", bus.outWord, 32'h01234567);
    idle(2);

    // Continuous stream: no bubbles, slot cycles twice.
    push(32'h01234567, 4'd8);
    push(32'h89ABCDEF, 4'd8);
    for (int i = 0; i < 16; i++) begin
      chk("t4_slot", 32'(bus.outSlot), 32'(i % 8));
      send(4'(i), 1'b0, w);
      chk("t4_wait", 32'(w), 32'd0);
    end
    idle(2);

    // Async reset mid-word discards the partial word.
    for (int i = 1; i <= 5; i++) begin
      send(4'(i), 1'b0, w);
    end
    bus.inValid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.outValid), 32'd0);
    chk("t5_word", bus.outWord, 32'h0);
    chk("t5_count", 32'(bus.outCount), 32'd0);
    chk("t5_slot", 32'(bus.outSlot), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'hFFFFFFFF, 4'd8);
    for (int i = 0; i < 8; i++) begin
      send(4'hF, 1'b0, w);
    end
    idle(2);

    // inLast on slot 7, then inLast on slot 0.
    push(32'h12345678, 4'd8);
    push(32'h90000000, 4'd1);
    for (int i = 1; i <= 8; i++) begin
      send(4'(i), (i == 8), w);
    end
    send(4'h9, 1'b1, w);
    chk("t6_word", bus.outWord, 32'h90000000);
    chk("t6_count", 32'(bus.outCount), 32'd1);
    idle(4);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/symbol_word_packer.md
Name: symbol_word_packer

Overview:
- Collects a stream of 4-bit Zigbee symbols into 32-bit words of 8 symbol slots.
- Slot k occupies outWord[31-4k : 28-4k], so slot 0 is the MSB nibble. This is the same slot mapping as the team's 1:8 nibble demultiplexer.
- Sits at the boundary between the symbol stream and the word-oriented chip/packet logic.
- Adds the sequencing the demultiplexer lacks: a slot counter, accumulation, valid/ready handshakes on both sides, and early word termination.

Parameters:
- SYM_W, 4, symbol width in bits. Fixed for this design; any other value is not supported.
- NSYM, 8, symbols per word. The word width is SYM_W*NSYM = 32.

Ports:
- inClk  input  1  clock; all state updates on the rising edge.
- inResetN  input  1  asynchronous active-low reset.
- inData  input  4  symbol.
- inValid  input  1  symbol present on inData.
- inLast  input  1  qualifies inData; the beat closes the current word early.
- outReadyIn  output  1  the packer can accept the current beat.
- outWord  output  32  packed word. Unused slots are zero.
- outCount  output  4  number of valid symbols in outWord, range 1..8.
- outValid  output  1  outWord/outCount are valid.
- inReady  input  1  downstream accepts the word.
- outSlot  output  3  slot index the next accepted symbol will occupy.

Behaviour:
- Reset (inResetN=0, asynchronous, any time including mid-word):
  - acc=0, slot=0, outWord=0, outCount=0, outValid=0, outSlot=0.
  - Any partial word is discarded. There is no post-reset residue.
- Definitions:
  - outFree = !outValid || inReady.
  - outReadyIn = outFree || (slot != 7 && !inLast). This is combinational from inLast, inReady and state.
  - Accept = inValid && outReadyIn.
  - Closing beat = accepted beat with slot==7 or inLast==1.
- Non-closing accepted beat:
  - acc slot field <= inData.
  - If slot==0, all other acc fields <= 0 (a fresh word starts clean).
  - slot <= slot+1.
- Closing accepted beat:
  - outWord <= acc with the current slot field = inData. Fields above the current slot are zero when slot==0; fields below the current slot are zero.
  - outCount <= slot+1.
  - outValid <= 1, slot <= 0.
  - Latency: the word is visible the cycle after the closing beat.
- Output handshake:
  - Word transfers when outValid && inReady.
  - If a transfer and a new closing beat coincide, the new word loads and outValid stays 1. This gives full throughput: one symbol per cycle, one word per 8 cycles, with no bubble.
  - If a transfer occurs with no closing beat, outValid <= 0. outWord and outCount hold their last value.
  - outWord and outCount are stable while outValid && !inReady.
- Back-pressure:
  - With the output occupied and not draining, the block accumulates slots 0..6 normally.
  - It stalls (outReadyIn=0) only on the slot-7 beat or an inLast beat, until outFree.
- inValid=0: no state change to acc/slot. inData and inLast are ignored.
- No empty words: words are emitted only by accepted closing beats, so outCount is never 0 while outValid=1.
- outSlot = slot at all times (registered state, not a function of the current beat).
- Wrap-around: slot wraps 7 -> 0 only via a closing beat, never by overflow.

Test Plan:
- Reset, inReady=1, feed symbols 1..8 on consecutive cycles -> one cycle after the 8th beat: outWord=0x12345678, outCount=8, outValid=1 for exactly 1 cycle.
- Feed A, B, C with inLast on C -> outWord=0xABC00000, outCount=3. Next word 0..7 -> 0x01234567, count 8, with no leftover 0xB/0xC.
- inReady=0 after first word: second word's symbols 0..6 are accepted, outReadyIn drops on 8th beat. Raise inReady -> first word transfers; the 8th beat is accepted the same cycle. Next cycle: second word valid, no symbol lost or duplicated.
- 16 symbols, inValid=1 and inReady=1 continuously -> outReadyIn never low, two words emitted 8 cycles apart, outSlot cycles 0..7 twice.
- 5 symbols, then assert inResetN=0 asynchronously mid-cycle -> all outputs 0 immediately. Then feed 8 symbols 0xF -> outWord=0xFFFFFFFF, count 8.
- inLast on 8th symbol, and inLast on the first symbol (value 0x9) -> count 8, then outWord=0x90000000 with count 1.
